// File: rtl/pc_seq_pkg.sv
// Shared constants and state encoding for the fetch-stage PC sequencer.
// Default address width, reset/exception vectors and instruction step live here.
package pc_seq_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam logic [31:0] RESET_VEC = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VEC   = 32'hBFC0_0380;
    localparam int unsigned INSN_STEP = 4;

    typedef enum logic {
        ST_SEQ  = 1'b0,
        ST_SLOT = 1'b1
    } seq_state_e;

endpackage

// File: rtl/pc_seq.sv
// Program-counter sequencer: sequential advance, one-instruction branch delay slot,
// exception vectoring with EPC/branch-delay capture, and ERET.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_SEQ  | normal sequential fetch; a redirect here opens a delay slot
// ST_SLOT | addr_o is the delay-slot instruction; tgt_q is fetched next
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int unsigned      WIDTH      = ADDR_W,
    parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(RESET_VEC),
    parameter logic [WIDTH-1:0] EXC_ADDR   = WIDTH'(EXC_VEC),
    parameter int unsigned      STEP       = INSN_STEP
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_addr_i,
    input  logic             exc_i,
    input  logic             eret_i,
    output logic [WIDTH-1:0] addr_o,
    output logic [WIDTH-1:0] epc_o,
    output logic             in_slot_o,
    output logic             bd_o
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic             bd_q, bd_d;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_SEQ;
            addr_q  <= RESET_ADDR;
            epc_q   <= '0;
            tgt_q   <= '0;
            bd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            epc_q   <= epc_d;
            tgt_q   <= tgt_d;
            bd_q    <= bd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (exc_i) begin
            state_d = ST_SEQ;
        end else if (!enable_i) begin
            state_d = state_q;
        end else if (eret_i) begin
            state_d = ST_SEQ;
        end else if (state_q == ST_SLOT) begin
            state_d = ST_SEQ;
        end else if (redirect_i) begin
            state_d = ST_SLOT;
        end
    end

    // Next-PC priority mux; exception beats stall so the vector is never delayed.
    always_comb begin
        addr_d = addr_q;
        epc_d  = epc_q;
        tgt_d  = tgt_q;
        bd_d   = bd_q;
        if (exc_i) begin
            addr_d = EXC_ADDR;
            tgt_d  = '0;
            if (state_q == ST_SLOT) begin
                epc_d = addr_q - STEP_W;
                bd_d  = 1'b1;
            end else begin
                epc_d = addr_q;
                bd_d  = 1'b0;
            end
        end else if (!enable_i) begin
            addr_d = addr_q;
        end else if (eret_i) begin
            addr_d = epc_q;
        end else if (state_q == ST_SLOT) begin
            addr_d = tgt_q;
        end else if (redirect_i) begin
            tgt_d  = redirect_addr_i;
            addr_d = addr_q + STEP_W;
        end else begin
            addr_d = addr_q + STEP_W;
        end
    end

    always_comb begin
        addr_o    = addr_q;
        epc_o     = epc_q;
        bd_o      = bd_q;
        in_slot_o = (state_q == ST_SLOT);
    end

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed vector table, hand-written corner
// sequences, randomized run against a queue-based reference model, 16-bit wrap.
module tb_pc_seq;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        enable_i, redirect_i, exc_i, eret_i;
    logic [31:0] redirect_addr_i;
    logic [31:0] addr_o, epc_o;
    logic        in_slot_o, bd_o;

    logic        s_rst, s_en, s_redir, s_exc, s_eret;
    logic [15:0] s_raddr, s_addr, s_epc;
    logic        s_slot, s_bd;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    pc_seq dut (
        .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i),
        .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
        .exc_i(exc_i), .eret_i(eret_i),
        .addr_o(addr_o), .epc_o(epc_o), .in_slot_o(in_slot_o), .bd_o(bd_o)
    );

    pc_seq #(.WIDTH(16), .RESET_ADDR(16'hFFFE), .EXC_ADDR(16'h0380), .STEP(2)) dut16 (
        .clk_i(clk_i), .reset_i(s_rst), .enable_i(s_en),
        .redirect_i(s_redir), .redirect_addr_i(s_raddr),
        .exc_i(s_exc), .eret_i(s_eret),
        .addr_o(s_addr), .epc_o(s_epc), .in_slot_o(s_slot), .bd_o(s_bd)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input logic redir, input logic [31:0] ra,
                         input logic exc, input logic eret);
        enable_i        = en;
        redirect_i      = redir;
        redirect_addr_i = ra;
        exc_i           = exc;
        eret_i          = eret;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] a, input logic sl,
                           input logic [31:0] e, input logic b);
        chk({tag, "_addr"}, addr_o, a);
        chk({tag, "_slot"}, 32'(in_slot_o), 32'(sl));
        chk({tag, "_epc"},  epc_o, e);
        chk({tag, "_bd"},   32'(bd_o), 32'(b));
    endtask

    typedef struct {
        logic        en;
        logic        redir;
        logic [31:0] raddr;
        logic        exc;
        logic        eret;
        logic [31:0] e_addr;
        logic        e_slot;
        logic [31:0] e_epc;
        logic        e_bd;
    } vec_t;

    vec_t tbl[25];

    // Reference model: pending redirect kept as a queue of targets.
    logic [31:0] m_pc, m_epc;
    logic        m_bd;
    logic [31:0] pend[$];

    task automatic model_step(input logic en, input logic redir, input logic [31:0] ra,
                              input logic exc, input logic eret);
        if (exc) begin
            m_epc = (pend.size() != 0) ? m_pc - 32'd4 : m_pc;
            m_bd  = (pend.size() != 0);
            m_pc  = 32'hBFC0_0380;
            pend.delete();
        end else if (en) begin
            if (eret) begin
                m_pc = m_epc;
                pend.delete();
            end else if (pend.size() != 0) begin
                m_pc = pend.pop_front();
            end else begin
                m_pc = m_pc + 32'd4;
                if (redir) pend.push_back(ra);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // 16-bit instance: reset value and wrap to zero.
    initial begin
        s_rst = 1'b0; s_en = 1'b1; s_redir = 1'b0; s_exc = 1'b0; s_eret = 1'b0;
        s_raddr = 16'h0;
        #13;
        chk("w16_reset", 32'(s_addr), 32'h0000_FFFE);
        s_rst = 1'b1;
        @(posedge clk_i); #2;
        chk("w16_wrap", 32'(s_addr), 32'h0000_0000);
        @(posedge clk_i); #2;
        chk("w16_next", 32'(s_addr), 32'h0000_0002);
        s_exc = 1'b1;
        @(posedge clk_i); #2;
        s_exc = 1'b0;
        chk("w16_vec", 32'(s_addr), 32'h0000_0380);
        chk("w16_epc", 32'(s_epc), 32'h0000_0002);
    end

    initial begin
        //          en    redir raddr         exc   eret  addr          slot  epc           bd
        tbl[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'hBFC00004, 1'b0, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'hBFC00008, 1'b0, 32'h0,        1'b0};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'hBFC0000C, 1'b0, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'hBFC00010, 1'b0, 32'h0,        1'b0};
        tbl[4]  = '{1'b1, 1'b1, 32'h00400000, 1'b0, 1'b0, 32'hBFC00014, 1'b1, 32'h0,        1'b0};
        tbl[5]  = '{1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0, 32'h00400000, 1'b0, 32'h0,        1'b0};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h00400004, 1'b0, 32'h0,        1'b0};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h00400008, 1'b0, 32'h0,        1'b0};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'hBFC00380, 1'b0, 32'h00400008, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h00400008, 1'b0, 32'h00400008, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 32'h00500000, 1'b0, 1'b0, 32'h0040000C, 1'b1, 32'h00400008, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0040000C, 1'b1, 32'h00400008, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0040000C, 1'b1, 32'h00400008, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0040000C, 1'b1, 32'h00400008, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h00500000, 1'b0, 32'h00400008, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 32'h00600000, 1'b0, 1'b0, 32'h00500004, 1'b1, 32'h00400008, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'hBFC00380, 1'b0, 32'h00500000, 1'b1};
        tbl[17] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'hBFC00384, 1'b0, 32'h00500000, 1'b1};
        tbl[18] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'hBFC00380, 1'b0, 32'hBFC00384, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'hBFC00384, 1'b0, 32'hBFC00384, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'hBFC00380, 1'b0, 32'hBFC00384, 1'b0};
        tbl[21] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'hBFC00380, 1'b0, 32'hBFC00384, 1'b0};
        tbl[22] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hBFC00380, 1'b0, 32'hBFC00384, 1'b0};
        tbl[23] = '{1'b1, 1'b1, 32'h00700000, 1'b0, 1'b0, 32'hBFC00384, 1'b1, 32'hBFC00384, 1'b0};
        tbl[24] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'hBFC00380, 1'b0, 32'hBFC00380, 1'b1};

        reset_i = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        #12;
        chk_all("reset", 32'hBFC00000, 1'b0, 32'h0, 1'b0);
        reset_i = 1'b1;

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].en, tbl[i].redir, tbl[i].raddr, tbl[i].exc, tbl[i].eret);
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].e_addr, tbl[i].e_slot, tbl[i].e_epc, tbl[i].e_bd);
        end

        // Async reset between edges while a redirect is pending.
        drive(1'b1, 1'b1, 32'h00800000, 1'b0, 1'b0);
        tick();
        chk_all("pre_rst", 32'hBFC00384, 1'b1, 32'hBFC00380, 1'b1);
        #3;
        reset_i = 1'b0;
        #1;
        chk_all("async_rst", 32'hBFC00000, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        reset_i = 1'b1;
        tick();
        chk_all("post_rst", 32'hBFC00004, 1'b0, 32'h0, 1'b0);

        // Exception in the delay slot of a branch at BFC00010.
        for (int i = 0; i < 3; i++) tick();
        chk("seq_to_10", addr_o, 32'hBFC00010);
        drive(1'b1, 1'b1, 32'h00400000, 1'b0, 1'b0);
        tick();
        chk_all("slot_b14", 32'hBFC00014, 1'b1, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk_all("exc_slot", 32'hBFC00380, 1'b0, 32'hBFC00010, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        chk_all("no_tgt", 32'hBFC00384, 1'b0, 32'hBFC00010, 1'b1);

        m_pc  = 32'hBFC00384;
        m_epc = 32'hBFC00010;
        m_bd  = 1'b1;
        pend.delete();
        for (int i = 0; i < 400; i++) begin
            logic        en, rd, ex, er;
            logic [31:0] ra;
            en = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 3) == 0);
            ex = ($urandom_range(0, 15) == 0);
            er = ($urandom_range(0, 9) == 0);
            ra = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            drive(en, rd, ra, ex, er);
            model_step(en, rd, ra, ex, er);
            tick();
            chk_all("rand", m_pc, (pend.size() != 0), m_epc, m_bd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
